gate_truth_table_probe: RTL and testbench

- Sequential stimulus/response engine for any 2-input combinational gate in the library (OR_GATE, NAND_GATE, ...).
- Drives the gate's in0/in1 through all four combinations and captures the gate's out into a 4-bit truth table.
- Compares the captured table against an expected pattern.
- Used as the on-chip counterpart of the gate modules: the gate answers, this block asks and records.

---
 rtl/gate_truth_table_probe_if.sv | 69 ++++++
 rtl/gate_truth_table_probe.sv | 177 +++++++++++++++++
 tb/tb_gate_truth_table_probe.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_truth_table_probe_if.sv
// Bundle of signals between the truth-table probe and its surroundings.
// The master side is the probe itself: it drives the gate inputs and reports
// the result; the slave side is the environment that starts runs and hosts
// the gate under probe.
// Optional: GATE_PROBE_ERRCNT_EN adds the 8-bit err_count result signal.

interface gate_truth_table_probe_if;

  logic       start;
  logic       dut_out;
  logic       drv_in0;
  logic       drv_in1;
  logic       busy;
  logic       done;
  logic [3:0] table_out;
  logic       match;
`ifdef GATE_PROBE_ERRCNT_EN
  logic [7:0] err_count;
`endif

`ifdef GATE_PROBE_ERRCNT_EN
  modport master (
    input  start,
    input  dut_out,
    output drv_in0,
    output drv_in1,
    output busy,
    output done,
    output table_out,
    output match,
    output err_count
  );

  modport slave (
    output start,
    output dut_out,
    input  drv_in0,
    input  drv_in1,
    input  busy,
    input  done,
    input  table_out,
    input  match,
    input  err_count
  );
`else
  modport master (
    input  start,
    input  dut_out,
    output drv_in0,
    output drv_in1,
    output busy,
    output done,
    output table_out,
    output match
  );

  modport slave (
    output start,
    output dut_out,
    input  drv_in0,
    input  drv_in1,
    input  busy,
    input  done,
    input  table_out,
    input  match
  );
`endif

endinterface

// File: rtl/gate_truth_table_probe.sv
// Truth-table probe for a 2-input combinational gate.
// Walks {in1,in0} through 00, 01, 10, 11, holds each combination for
// SETTLE_CYCLES cycles, samples the gate output on the last cycle of each
// hold, and compares the collected 4-bit table against EXPECTED.
// Optional: define GATE_PROBE_ERRCNT_EN to add a saturating count of
// mismatching runs (err_count on the interface), cleared only by reset.
// SETTLE_CYCLES legal range is 1..255 (the settle counter is 8 bits wide).

module gate_truth_table_probe #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [3:0]  EXPECTED      = 4'b1110
) (
  input logic                      clk,
  input logic                      rst_n,
  gate_truth_table_probe_if.master bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrive = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  // Counter value on which the current combination is sampled.
  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       drv0_q, drv0_d;
  logic       drv1_q, drv1_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] table_q, table_d;
  logic       match_q, match_d;
`ifdef GATE_PROBE_ERRCNT_EN
  logic [7:0] err_q, err_d;
`endif

  // Helpers for the sampling edge.
  logic       sample_now;
  logic [3:0] table_smp;
  logic [1:0] idx_nxt;

  assign sample_now = (cnt_q == SettleLast);
  assign idx_nxt    = idx_q + 2'd1;

  // Table as it will look after the current sample is written in; used so the
  // match flag on entry to DONE already includes the final bit.
  always_comb begin
    table_smp         = table_q;
    table_smp[idx_q]  = bus.dut_out;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    drv0_d  = drv0_q;
    drv1_d  = drv1_q;
    busy_d  = busy_q;
    done_d  = done_q;
    table_d = table_q;
    match_d = match_q;
`ifdef GATE_PROBE_ERRCNT_EN
    err_d   = err_q;
`endif

    case (state_q)
      StIdle, StDone: begin
        // A run starts from a clean slate whether or not a result is held.
        if (bus.start) begin
          state_d = StDrive;
          idx_d   = 2'd0;
          cnt_d   = 8'd0;
          drv0_d  = 1'b0;
          drv1_d  = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          table_d = 4'b0000;
          match_d = 1'b0;
        end
      end

      StDrive: begin
        // start is deliberately not looked at here: runs are never extended.
        if (sample_now) begin
          cnt_d   = 8'd0;
          table_d = table_smp;
          if (idx_q == 2'd3) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            drv0_d  = 1'b0;
            drv1_d  = 1'b0;
            match_d = (table_smp == EXPECTED);
`ifdef GATE_PROBE_ERRCNT_EN
            if ((table_smp != EXPECTED) && (err_q != 8'hFF)) begin
              err_d = err_q + 8'd1;
            end
`endif
          end else begin
            idx_d  = idx_nxt;
            drv0_d = idx_nxt[0];
            drv1_d = idx_nxt[1];
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a quiet idle.
        state_d = StIdle;
        idx_d   = 2'd0;
        cnt_d   = 8'd0;
        drv0_d  = 1'b0;
        drv1_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        table_d = 4'b0000;
        match_d = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset discards any partial run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      cnt_q   <= 8'd0;
      drv0_q  <= 1'b0;
      drv1_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= 4'b0000;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drv0_q  <= drv0_d;
      drv1_q  <= drv1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      match_q <= match_d;
    end
  end

`ifdef GATE_PROBE_ERRCNT_EN
  // Mismatch counter survives new runs; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 8'd0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_count = err_q;
`endif

  assign bus.drv_in0   = drv0_q;
  assign bus.drv_in1   = drv1_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.table_out = table_q;
  assign bus.match     = match_q;

  // Running and holding a result are mutually exclusive.
  assert property (@(posedge clk) disable iff (!rst_n) !(busy_q && done_q));

  // Gate inputs are only ever non-zero during a run.
  assert property (@(posedge clk) disable iff (!rst_n) (drv0_q || drv1_q) |-> busy_q);

endmodule

// File: tb/tb_gate_truth_table_probe.sv
// Directed bench for gate_truth_table_probe.
// Three probes share clock and reset: a default probe whose gate model can be
// switched between OR and AND, an OR probe with a 3-cycle settle time, and a
// NAND probe expecting 4'b0111.

module tb_gate_truth_table_probe;

  logic clk;
  logic rst_n;
  logic gate_sel;  // 0: OR model on probe A, 1: AND model

  int total;
  int bad;

  gate_truth_table_probe_if ifa ();
  gate_truth_table_probe_if ifb ();
  gate_truth_table_probe_if ifc ();

  assign ifa.dut_out = gate_sel ? (ifa.drv_in0 & ifa.drv_in1) : (ifa.drv_in0 | ifa.drv_in1);
  assign ifb.dut_out = ifb.drv_in0 | ifb.drv_in1;
  assign ifc.dut_out = ~(ifc.drv_in0 & ifc.drv_in1);

  gate_truth_table_probe #(
    .SETTLE_CYCLES (1),
    .EXPECTED      (4'b1110)
  ) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  gate_truth_table_probe #(
    .SETTLE_CYCLES (3),
    .EXPECTED      (4'b1110)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  gate_truth_table_probe #(
    .SETTLE_CYCLES (1),
    .EXPECTED      (4'b0111)
  ) u_dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    ifc.start = 1'b0;
    tick();
    tick();
    total++;
    if ({ifa.drv_in1, ifa.drv_in0, ifa.busy, ifa.done, ifa.table_out, ifa.match} !== 9'd0) begin
      bad++;
      $display("FAIL reset_a: drv=%b%b busy=%b done=%b table=%b match=%b, want all 0",
               ifa.drv_in1, ifa.drv_in0, ifa.busy, ifa.done, ifa.table_out, ifa.match);
    end
    total++;
    if ({ifb.drv_in1, ifb.drv_in0, ifb.busy, ifb.done, ifb.table_out, ifb.match} !== 9'd0) begin
      bad++;
      $display("FAIL reset_b: drv=%b%b busy=%b done=%b table=%b match=%b, want all 0",
               ifb.drv_in1, ifb.drv_in0, ifb.busy, ifb.done, ifb.table_out, ifb.match);
    end
`ifdef GATE_PROBE_ERRCNT_EN
    total++;
    if (ifa.err_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_errcnt: got %0d want 0", ifa.err_count);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_or_default();
    logic [1:0] exp_drv;
    gate_sel = 1'b0;
    total++;
    if ({ifa.drv_in1, ifa.drv_in0, ifa.busy} !== 3'b000) begin
      bad++;
      $display("FAIL or_idle: drv=%b%b busy=%b, want drv=00 busy=0",
               ifa.drv_in1, ifa.drv_in0, ifa.busy);
    end
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_drv = k[1:0];
      total++;
      if ({ifa.drv_in1, ifa.drv_in0} !== exp_drv || ifa.busy !== 1'b1 || ifa.done !== 1'b0) begin
        bad++;
        $display("FAIL or_drv step %0d: drv=%b%b busy=%b done=%b, want drv=%b busy=1 done=0",
                 k, ifa.drv_in1, ifa.drv_in0, ifa.busy, ifa.done, exp_drv);
      end
      tick();
    end
    total++;
    if (ifa.done !== 1'b1 || ifa.busy !== 1'b0 || ifa.table_out !== 4'b1110 ||
        ifa.match !== 1'b1 || {ifa.drv_in1, ifa.drv_in0} !== 2'b00) begin
      bad++;
      $display("FAIL or_result: done=%b busy=%b table=%b match=%b drv=%b%b, want 1 0 1110 1 00",
               ifa.done, ifa.busy, ifa.table_out, ifa.match, ifa.drv_in1, ifa.drv_in0);
    end
    tick();
    total++;
    if (ifa.done !== 1'b1 || ifa.table_out !== 4'b1110) begin
      bad++;
      $display("FAIL or_hold: done=%b table=%b, want done=1 table=1110", ifa.done, ifa.table_out);
    end
  endtask

  task automatic test_and_mismatch();
    gate_sel = 1'b1;
    for (int r = 0; r < 2; r++) begin
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      for (int i = 0; i < 20 && ifa.done !== 1'b1; i++) tick();
      total++;
      if (ifa.done !== 1'b1 || ifa.table_out !== 4'b1000 || ifa.match !== 1'b0) begin
        bad++;
        $display("FAIL and_run %0d: done=%b table=%b match=%b, want done=1 table=1000 match=0",
                 r, ifa.done, ifa.table_out, ifa.match);
      end
`ifdef GATE_PROBE_ERRCNT_EN
      total++;
      if (ifa.err_count !== 8'(r + 1)) begin
        bad++;
        $display("FAIL and_errcnt %0d: got %0d want %0d", r, ifa.err_count, r + 1);
      end
`endif
      tick();
    end
    gate_sel = 1'b0;
  endtask

  task automatic test_settle3();
    logic [1:0] exp_drv;
    int busy_cycles;
    busy_cycles = 0;
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      exp_drv = 2'(k / 3);
      if (ifb.busy === 1'b1) busy_cycles++;
      total++;
      if ({ifb.drv_in1, ifb.drv_in0} !== exp_drv || ifb.done !== 1'b0) begin
        bad++;
        $display("FAIL s3_drv cycle %0d: drv=%b%b done=%b, want drv=%b done=0",
                 k, ifb.drv_in1, ifb.drv_in0, ifb.done, exp_drv);
      end
      tick();
    end
    total++;
    if (busy_cycles != 12) begin
      bad++;
      $display("FAIL s3_busy_len: got %0d want 12", busy_cycles);
    end
    total++;
    if (ifb.done !== 1'b1 || ifb.busy !== 1'b0 || ifb.table_out !== 4'b1110 ||
        ifb.match !== 1'b1) begin
      bad++;
      $display("FAIL s3_result: done=%b busy=%b table=%b match=%b, want 1 0 1110 1",
               ifb.done, ifb.busy, ifb.table_out, ifb.match);
    end
  endtask

  task automatic test_start_held();
    int busy_cycles;
    busy_cycles = 0;
    gate_sel = 1'b0;
    ifa.start = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (ifa.busy === 1'b1 && ifa.done === 1'b0) busy_cycles++;
      tick();
    end
    total++;
    if (busy_cycles != 4 || ifa.busy !== 1'b0 || ifa.done !== 1'b1 ||
        ifa.table_out !== 4'b1110) begin
      bad++;
      $display("FAIL held_single_run: busy_cycles=%0d busy=%b done=%b table=%b, want 4 0 1 1110",
               busy_cycles, ifa.busy, ifa.done, ifa.table_out);
    end
    tick();
    total++;
    if (ifa.busy !== 1'b1 || ifa.done !== 1'b0 || ifa.table_out !== 4'b0000 ||
        {ifa.drv_in1, ifa.drv_in0} !== 2'b00) begin
      bad++;
      $display("FAIL held_restart: busy=%b done=%b table=%b drv=%b%b, want 1 0 0000 00",
               ifa.busy, ifa.done, ifa.table_out, ifa.drv_in1, ifa.drv_in0);
    end
    ifa.start = 1'b0;
    for (int i = 0; i < 20 && ifa.done !== 1'b1; i++) tick();
    total++;
    if (ifa.done !== 1'b1 || ifa.table_out !== 4'b1110) begin
      bad++;
      $display("FAIL held_second: done=%b table=%b, want done=1 table=1110",
               ifa.done, ifa.table_out);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    gate_sel = 1'b0;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    tick();
    tick();
    total++;
    if ({ifa.drv_in1, ifa.drv_in0} !== 2'b10 || ifa.busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre: drv=%b%b busy=%b, want drv=10 busy=1",
               ifa.drv_in1, ifa.drv_in0, ifa.busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if ({ifa.drv_in1, ifa.drv_in0, ifa.busy, ifa.done, ifa.table_out, ifa.match} !== 9'd0) begin
      bad++;
      $display("FAIL midrst_clear: drv=%b%b busy=%b done=%b table=%b match=%b, want all 0",
               ifa.drv_in1, ifa.drv_in0, ifa.busy, ifa.done, ifa.table_out, ifa.match);
    end
    tick();
    total++;
    if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
      bad++;
      $display("FAIL midrst_idle: busy=%b done=%b, want 0 0", ifa.busy, ifa.done);
    end
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int i = 0; i < 20 && ifa.done !== 1'b1; i++) tick();
    total++;
    if (ifa.done !== 1'b1 || ifa.table_out !== 4'b1110 || ifa.match !== 1'b1) begin
      bad++;
      $display("FAIL midrst_rerun: done=%b table=%b match=%b, want 1 1110 1",
               ifa.done, ifa.table_out, ifa.match);
    end
`ifdef GATE_PROBE_ERRCNT_EN
    total++;
    if (ifa.err_count !== 8'd0) begin
      bad++;
      $display("FAIL midrst_errcnt: got %0d want 0", ifa.err_count);
    end
`endif
    tick();
  endtask

  task automatic test_nand();
    logic [1:0] exp_drv;
    total++;
    if ({ifc.drv_in1, ifc.drv_in0} !== 2'b00 || ifc.busy !== 1'b0) begin
      bad++;
      $display("FAIL nand_idle: drv=%b%b busy=%b, want 00 0", ifc.drv_in1, ifc.drv_in0, ifc.busy);
    end
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_drv = k[1:0];
      total++;
      if ({ifc.drv_in1, ifc.drv_in0} !== exp_drv) begin
        bad++;
        $display("FAIL nand_drv step %0d: drv=%b%b want %b", k, ifc.drv_in1, ifc.drv_in0, exp_drv);
      end
      tick();
    end
    total++;
    if (ifc.done !== 1'b1 || ifc.table_out !== 4'b0111 || ifc.match !== 1'b1 ||
        {ifc.drv_in1, ifc.drv_in0} !== 2'b00) begin
      bad++;
      $display("FAIL nand_result: done=%b table=%b match=%b drv=%b%b, want 1 0111 1 00",
               ifc.done, ifc.table_out, ifc.match, ifc.drv_in1, ifc.drv_in0);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    gate_sel  = 1'b0;
    rst_n     = 1'b0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    ifc.start = 1'b0;
    test_reset();
    test_or_default();
    test_and_mismatch();
    test_settle3();
    test_start_held();
    test_reset_mid_run();
    test_nand();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
